aes_round_engine: RTL and testbench
===================================

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 Parameter NR, default 10, meaning number of AES rounds; legal values 10, 12, 14 (AES-128/192/256).
REQ-002 Parameter SB_REG, default 1, meaning 1 = registered S-box stage (2 cycles per round), 0 = combinational S-box (1 cycle per round).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  plaintext block offered.
REQ-006 in_ready  output  1  engine accepts a block this cycle.
REQ-007 in_data  input  128  plaintext; byte 0 = in_data[127:120], column-major FIPS-197 order.
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 out_data  output  128  ciphertext, same byte order as in_data.
REQ-011 rk_idx  output  4  index of round key requested, 0..NR.
REQ-012 rk_data  input  128  round key for rk_idx, supplied combinationally in the same cycle by the external key schedule.
REQ-013 busy  output  1  high while a block is being processed or held in DONE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-016 In IDLE rk_idx SHALL be 0; on transfer the state register SHALL load in_data ^ rk_data, the round counter SHALL load 1, FSM -> ROUND.
REQ-017 In ROUND, rk_idx SHALL equal the round counter and stay constant for all cycles of that round; rk_data SHALL be sampled on the last cycle of the round only.
REQ-018 Each round SHALL take 1 + SB_REG cycles; with SB_REG=1 the first cycle registers SubBytes output, the second applies ShiftRows, MixColumns, AddRoundKey into the state register.
REQ-019 Rounds 1..NR-1 SHALL apply SubBytes, ShiftRows, MixColumns, AddRoundKey; round NR SHALL omit MixColumns.
REQ-020 After round NR completes, out_data SHALL hold the result, out_valid SHALL be 1, FSM -> DONE, rk_idx -> 0.
REQ-021 Latency from accept cycle to first out_valid cycle SHALL be exactly NR*(1+SB_REG) cycles (20 for defaults).
REQ-022 In DONE, out_valid and out_data SHALL hold stable until out_ready; on out_valid && out_ready FSM -> IDLE and out_valid -> 0 next cycle.
REQ-023 No input SHALL be accepted in ROUND or DONE; in_valid there SHALL be ignored with no state change.
REQ-024 Round counter SHALL be 4 bits, never exceed NR, and wrap to 0 on return to IDLE.
REQ-025 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11B.
REQ-026 busy SHALL equal (FSM != IDLE).

Reset
REQ-027 rst_n low SHALL immediately force FSM=IDLE, round counter=0, state register=0, out_data=0, out_valid=0, busy=0, rk_idx=0, S-box stage register=0.
REQ-028 Reset asserted mid-operation SHALL abort the block with no out_valid; in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-029 Shared package aes_pkg SHALL hold the S-box table, xtime function, AES state typedef (16 x 8 bit), and NR constants for 128/192/256.
REQ-030 Sub-module aes_round_core SHALL implement one round (inputs state, key, final flag; SB_REG parameter), instantiated once and reused iteratively.
REQ-031 No combinational path from in_valid or out_ready to out_data.

Verification
REQ-032 NR=10, SB_REG=1, FIPS-197 key 000102...0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a after exactly 20 cycles.
REQ-033 NR=12, key 000102...17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 after 24 cycles; NR=14, key 00..1f -> 8ea2b7ca516745bfeafc49904b496089 after 28 cycles.
REQ-034 SB_REG=0, NR=10, FIPS vector -> same ciphertext after exactly 10 cycles; rk_idx sequence 0,1..10 one per cycle.
REQ-035 Hold out_ready=0 for 7 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst_n=0 at round 5 -> all outputs 0 same cycle, no out_valid; after release a new FIPS block completes correctly.
REQ-037 Back-to-back blocks with out_ready tied 1 -> each ciphertext correct, accept-to-accept spacing NR*(1+SB_REG)+2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box table and round transforms
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // FIPS byte k of the block lives in element [15-k], so bits [127:120] hold byte 0.
  typedef logic [15:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t r;
    for (int i = 0; i < 16; i++) r[i] = sbox(s[i]);
    return r;
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[15 - (row + 4*c)] = s[15 - (row + 4*((c + row) % 4))];
      end
    end
    return r;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[15 - 4*c];
      a1 = s[14 - 4*c];
      a2 = s[13 - 4*c];
      a3 = s[12 - 4*c];
      r[15 - 4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[14 - 4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[13 - 4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[12 - 4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// rtl/aes_round_engine_if.sv - block handshake and round-key request bundle
interface aes_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, out_ready, rk_data,
    output in_ready, out_valid, out_data, rk_idx, busy
  );

  modport master (
    output in_valid, in_data, out_ready, rk_data,
    input  in_ready, out_valid, out_data, rk_idx, busy
  );
endinterface

// File: rtl/aes_round_core.sv
// rtl/aes_round_core.sv - one AES round, SubBytes optionally registered
module aes_round_core
  import aes_pkg::*;
#(
  parameter int SB_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sb_load,
  input  aes_state_t   state_i,
  input  logic [127:0] key_i,
  input  logic         final_i,
  output aes_state_t   state_o
);

  aes_state_t sb_out;
  aes_state_t sr_out;

  if (SB_REG != 0) begin : g_sb_reg
    aes_state_t sb_q, sb_d;

    always_comb begin
      sb_d = sb_q;
      if (sb_load) sb_d = sub_bytes(state_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb_q <= '0;
      else        sb_q <= sb_d;
    end

    assign sb_out = sb_q;
  end else begin : g_sb_comb
    logic unused_sb;
    assign unused_sb = ^{clk, rst_n, sb_load};
    assign sb_out    = sub_bytes(state_i);
  end

  // The last round skips MixColumns.
  always_comb begin
    sr_out  = shift_rows(sb_out);
    state_o = (final_i ? sr_out : mix_columns(sr_out)) ^ key_i;
  end

endmodule

// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES encryption engine, one round core reused NR times
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NR     = NR_AES128,
  parameter int SB_REG = 1
) (
  input logic               clk,
  input logic               rst_n,
  aes_round_engine_if.slave io
);

  localparam logic [3:0] NR_LAST = 4'(NR);

  fsm_t       fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  aes_state_t st_q, st_d;
  logic       phase_q, phase_d;
  aes_state_t round_out;
  logic       last_cyc;
  logic       final_rnd;
  logic       sb_load;

  // With a registered S-box, phase 0 fills the S-box stage and phase 1 commits the round.
  assign last_cyc  = (SB_REG == 0) || phase_q;
  assign final_rnd = (rnd_q == NR_LAST);
  assign sb_load   = (fsm_q == ROUND) && !phase_q;

  aes_round_core #(
    .SB_REG(SB_REG)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .sb_load (sb_load),
    .state_i (st_q),
    .key_i   (io.rk_data),
    .final_i (final_rnd),
    .state_o (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    phase_d = phase_q;
    case (fsm_q)
      IDLE: begin
        if (io.in_valid) begin
          st_d    = io.in_data ^ io.rk_data;
          rnd_d   = 4'd1;
          phase_d = 1'b0;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (!last_cyc) begin
          phase_d = 1'b1;
        end else begin
          st_d    = round_out;
          phase_d = 1'b0;
          if (final_rnd) begin
            rnd_d = 4'd0;
            fsm_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (io.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      phase_q <= phase_d;
    end
  end

  // The round counter is zero outside ROUND, so it doubles as the key request index.
  assign io.in_ready  = (fsm_q == IDLE);
  assign io.out_valid = (fsm_q == DONE);
  assign io.busy      = (fsm_q != IDLE);
  assign io.out_data  = st_q;
  assign io.rk_idx    = rnd_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - bench for aes_round_engine in four NR/SB_REG configurations
module tb_aes_round_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid_a  [4];
  logic [127:0] in_data_a   [4];
  logic         out_ready_a [4];
  logic         in_ready_a  [4];
  logic         out_valid_a [4];
  logic         busy_a      [4];
  logic [127:0] out_data_a  [4];
  logic [3:0]   rk_idx_a    [4];
  logic [127:0] rk_tbl      [4][16];
  logic [7:0]   sb_m        [256];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int G_NR = (g == 1) ? 12 : ((g == 2) ? 14 : 10);
    localparam int G_SB = (g == 3) ? 0 : 1;
    aes_round_engine_if io_if ();
    aes_round_engine #(.NR(G_NR), .SB_REG(G_SB)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io_if)
    );
    assign io_if.in_valid  = in_valid_a[g];
    assign io_if.in_data   = in_data_a[g];
    assign io_if.out_ready = out_ready_a[g];
    assign io_if.rk_data   = rk_tbl[g][io_if.rk_idx];
    assign in_ready_a[g]   = io_if.in_ready;
    assign out_valid_a[g]  = io_if.out_valid;
    assign busy_a[g]       = io_if.busy;
    assign out_data_a[g]   = io_if.out_data;
    assign rk_idx_a[g]     = io_if.rk_idx;
  end

  function automatic int nr_of(input int k);
    return (k == 1) ? 12 : ((k == 2) ? 14 : 10);
  endfunction

  function automatic int sb_of(input int k);
    return (k == 3) ? 0 : 1;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Reference S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nr;
    nr = nr_of(k);
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = {tmp[23:0], tmp[31:24]};
          tmp = {sb_m[tmp[31:24]], sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]]} ^ {rc, 24'h0};
          rc  = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          tmp = {sb_m[tmp[31:24]], sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]]};
        end
        w[i] = w[i-nk] ^ tmp;
      end
    end
    for (int r = 0; r < 16; r++) rk_tbl[k][r] = '0;
    for (int r = 0; r <= nr; r++) rk_tbl[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input int k, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    int nr;
    nr = nr_of(k);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tbl[k][0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) t[row] = s[4*c + row];
          for (int row = 0; row < 4; row++)
            s[4*c + row] = gmul(8'h02, t[row]) ^ gmul(8'h03, t[(row+1) % 4]) ^ t[(row+2) % 4] ^ t[(row+3) % 4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_tbl[k][r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cleared(input int k, input string tag);
    check($sformatf("%s/out_valid%0d", tag, k), 128'(out_valid_a[k]), 128'd0);
    check($sformatf("%s/busy%0d", tag, k), 128'(busy_a[k]), 128'd0);
    check($sformatf("%s/rk_idx%0d", tag, k), 128'(rk_idx_a[k]), 128'd0);
    check($sformatf("%s/out_data%0d", tag, k), out_data_a[k], 128'd0);
    check($sformatf("%s/in_ready%0d", tag, k), 128'(in_ready_a[k]), 128'd1);
  endtask

  task automatic run_block(input int k, input logic [127:0] pt, input logic [127:0] exp,
                           input int hold, input string tag);
    int cnt, lat, cpr;
    logic [127:0] held;
    cpr = 1 + sb_of(k);
    lat = nr_of(k) * cpr;
    out_ready_a[k] = 1'b0;
    in_data_a[k]   = pt;
    in_valid_a[k]  = 1'b1;
    cnt = 0;
    while (!in_ready_a[k] && cnt < 50) begin
      tick();
      cnt++;
    end
    check($sformatf("%s/in_ready", tag), 128'(in_ready_a[k]), 128'd1);
    check($sformatf("%s/rk_idx_accept", tag), 128'(rk_idx_a[k]), 128'd0);
    tick();
    in_valid_a[k] = 1'b0;
    in_data_a[k]  = rand128();
    cnt = 0;
    while (!out_valid_a[k] && cnt < lat + 10) begin
      check($sformatf("%s/rk_idx_c%0d", tag, cnt), 128'(rk_idx_a[k]), 128'(cnt / cpr + 1));
      tick();
      cnt++;
    end
    check($sformatf("%s/latency", tag), 128'(cnt), 128'(lat));
    check($sformatf("%s/out_data", tag), out_data_a[k], exp);
    check($sformatf("%s/rk_idx_done", tag), 128'(rk_idx_a[k]), 128'd0);
    check($sformatf("%s/busy_done", tag), 128'(busy_a[k]), 128'd1);
    held = exp;
    for (int h = 0; h < hold; h++) begin
      in_valid_a[k] = 1'b1;
      in_data_a[k]  = rand128();
      tick();
      check($sformatf("%s/hold%0d_data", tag, h), out_data_a[k], held);
      check($sformatf("%s/hold%0d_in_ready", tag, h), 128'(in_ready_a[k]), 128'd0);
      check($sformatf("%s/hold%0d_out_valid", tag, h), 128'(out_valid_a[k]), 128'd1);
    end
    in_valid_a[k]  = 1'b0;
    out_ready_a[k] = 1'b1;
    tick();
    out_ready_a[k] = 1'b0;
    check($sformatf("%s/released_valid", tag), 128'(out_valid_a[k]), 128'd0);
    check($sformatf("%s/released_ready", tag), 128'(in_ready_a[k]), 128'd1);
    check($sformatf("%s/released_busy", tag), 128'(busy_a[k]), 128'd0);
  endtask

  task automatic b2b(input int k, input int n);
    logic [127:0] exp_q [$];
    logic [127:0] e;
    int cyc, prev, nacc, nout, gap;
    logic acc;
    gap  = nr_of(k) * (1 + sb_of(k)) + 2;
    out_ready_a[k] = 1'b1;
    in_valid_a[k]  = 1'b1;
    in_data_a[k]   = rand128();
    cyc = 0; prev = -1; nacc = 0; nout = 0;
    while (nout < n && cyc < n * (gap + 5)) begin
      acc = in_ready_a[k] && in_valid_a[k];
      if (acc) begin
        if (prev >= 0) check($sformatf("b2b%0d/spacing%0d", k, nacc), 128'(cyc - prev), 128'(gap));
        prev = cyc;
        nacc++;
        exp_q.push_back(aes_ref(k, in_data_a[k]));
      end
      if (out_valid_a[k]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("b2b%0d/spurious", k), 128'(out_valid_a[k]), 128'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("b2b%0d/data%0d", k, nout), out_data_a[k], e);
          nout++;
        end
      end
      tick();
      cyc++;
      if (acc) begin
        in_data_a[k] = rand128();
        if (nacc == n) in_valid_a[k] = 1'b0;
      end
    end
    check($sformatf("b2b%0d/count", k), 128'(nout), 128'(n));
    in_valid_a[k]  = 1'b0;
    out_ready_a[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    logic         seen;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_a[k]  = 1'b0;
      in_data_a[k]   = '0;
      out_ready_a[k] = 1'b0;
      for (int r = 0; r < 16; r++) rk_tbl[k][r] = '0;
    end
    build_sbox();
    load_key(0, KEY128);
    load_key(1, KEY192);
    load_key(2, KEY256);
    load_key(3, KEY128);
    tick();
    tick();
    for (int k = 0; k < 4; k++) check_cleared(k, "reset");
    rst_n = 1'b1;
    tick();

    run_block(0, FIPS_PT, CT128, 7, "fips128_hold");
    run_block(1, FIPS_PT, CT192, 0, "fips192");
    run_block(2, FIPS_PT, CT256, 0, "fips256");
    run_block(3, FIPS_PT, CT128, 0, "fips128_comb");

    in_data_a[0]  = FIPS_PT;
    in_valid_a[0] = 1'b1;
    tick();
    in_valid_a[0] = 1'b0;
    repeat (8) tick();
    check("midrst/round5", 128'(rk_idx_a[0]), 128'd5);
    rst_n = 1'b0;
    #1;
    check_cleared(0, "midrst");
    tick();
    rst_n = 1'b1;
    check("midrst/in_ready_after", 128'(in_ready_a[0]), 128'd1);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (out_valid_a[0]) seen = 1'b1;
    end
    check("midrst/no_out_valid", 128'(seen), 128'd0);
    run_block(0, FIPS_PT, CT128, 0, "fips_after_rst");

    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        load_key(k, {rand128(), rand128()});
        pt = rand128();
        run_block(k, pt, aes_ref(k, pt), j, $sformatf("rand_k%0d_%0d", k, j));
      end
      b2b(k, 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
